// File: rtl/plusarg_timeout_ctrl_pkg.sv
// Shared types and constants for the plusarg cycle-limit watchdog.
package plusarg_timeout_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int unsigned LIMIT_DISABLED = 0;

endpackage

// File: rtl/plusarg_timeout_ctrl_if.sv
// Runtime limit-override write port (valid/ready).
interface plusarg_timeout_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_limit;

  modport master (output wr_valid, output wr_limit, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_limit, output wr_ready);
endinterface

// File: rtl/plusarg_timeout_ctrl_tick.sv
// Count-enable tick source; a 2^PRESCALE_LOG2 prescaler when
// PLUSARG_TIMEOUT_PRESCALE_EN is defined, otherwise a constant tick.
module plusarg_timeout_tick #(
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

`ifdef PLUSARG_TIMEOUT_PRESCALE_EN
  logic [PRESCALE_LOG2-1:0] pre;

  // Prescaler only advances while counting, so a pause freezes its phase.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pre <= '0;
    end else if (enable) begin
      pre <= pre + PRESCALE_LOG2'(1);
    end
  end

  assign tick = enable && (pre == '1);
`else
  localparam int unused_prescale = PRESCALE_LOG2;
  logic unused_in;
  assign unused_in = &{1'b0, clock, reset, clear, enable};
  assign tick = 1'b1;
`endif

endmodule

// File: rtl/plusarg_timeout_ctrl.sv
// Cycle-limit watchdog: limit latched from cfg_limit during reset, runtime
// override via write port. Optional prescaler: PLUSARG_TIMEOUT_PRESCALE_EN.
module plusarg_timeout_ctrl
  import plusarg_timeout_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            cfg_limit,
  plusarg_timeout_ctrl_if.slave  wr,
  input  logic                   kick,
  input  logic                   pause,
  output logic [WIDTH-1:0]       count,
  output state_t                 state,
  output logic                   timeout,
  output logic                   expired
);

  if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
    $error("plusarg_timeout_ctrl: WIDTH must be within 8..32");
  end

  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] cfg_w;
  logic [WIDTH-1:0] count_inc;
  logic             wr_fire;
  logic             tick;
  logic             at_limit;

  assign cfg_w       = cfg_limit[WIDTH-1:0];
  assign wr.wr_ready = !reset;
  assign wr_fire     = wr.wr_valid && !reset;
  assign count_inc   = count + WIDTH'(1);
  assign at_limit    = tick && (count_inc == limit_q);

  plusarg_timeout_tick #(
    .PRESCALE_LOG2 (PRESCALE_LOG2)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (wr_fire || kick),
    .enable (state == RUN),
    .tick   (tick)
  );

  // Priority: reset, accepted write, kick, expiry, pause.
  always_ff @(posedge clock) begin
    timeout <= 1'b0;
    if (reset) begin
      limit_q <= cfg_w;
      count   <= '0;
      expired <= 1'b0;
      state   <= (cfg_w != WIDTH'(LIMIT_DISABLED)) ? RUN : IDLE;
    end else if (wr_fire) begin
      limit_q <= wr.wr_limit;
      count   <= '0;
      expired <= 1'b0;
      state   <= (wr.wr_limit != WIDTH'(LIMIT_DISABLED)) ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          count <= '0;
        end
        RUN: begin
          if (kick) begin
            count <= '0;
          end else if (at_limit) begin
            count   <= limit_q;
            timeout <= 1'b1;
            expired <= 1'b1;
            state   <= EXPIRED;
          end else if (pause) begin
            state <= PAUSED;
          end else if (tick) begin
            count <= count_inc;
          end
        end
        PAUSED: begin
          if (kick) begin
            count <= '0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        EXPIRED: begin
          if (kick) begin
            count   <= '0;
            expired <= 1'b0;
            state   <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plusarg_timeout_ctrl.sv
// Directed bench for plusarg_timeout_ctrl.
module tb_plusarg_timeout_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] cfg_limit;
  logic        kick;
  logic        pause;
  logic [31:0] count;
  logic [1:0]  state;
  logic        timeout;
  logic        expired;
  int          total;
  int          bad;

  plusarg_timeout_ctrl_if #(.WIDTH(32)) wr_bus ();

  plusarg_timeout_ctrl #(
    .WIDTH         (32),
    .PRESCALE_LOG2 (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_limit (cfg_limit),
    .wr        (wr_bus.slave),
    .kick      (kick),
    .pause     (pause),
    .count     (count),
    .state     (state),
    .timeout   (timeout),
    .expired   (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] lim);
    reset = 1'b1;
    cfg_limit = lim;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_limit = 32'd10;
    step();
    step();
    total++; if (count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b want=0", timeout); end
    total++; if (expired !== 1'b0) begin bad++; $display("FAIL rst_expired got=%0b want=0", expired); end
    total++; if (wr_bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%0b want=0", wr_bus.wr_ready); end
    reset = 1'b0;
    #1;
    total++; if (wr_bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rel_wr_ready got=%0b want=1", wr_bus.wr_ready); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL rel_state got=%0d want=1", state); end
  endtask

  task automatic test_limit10();
    apply_reset(32'd10);
    for (int n = 1; n <= 10; n++) begin
      step();
      total++; if (count !== 32'(n)) begin bad++; $display("FAIL lim10_count cyc=%0d got=%0d want=%0d", n, count, n); end
      total++; if (timeout !== (n == 10)) begin bad++; $display("FAIL lim10_timeout cyc=%0d got=%0b want=%0b", n, timeout, (n == 10)); end
    end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL lim10_state got=%0d want=3", state); end
    total++; if (expired !== 1'b1) begin bad++; $display("FAIL lim10_expired got=%0b want=1", expired); end
    for (int n = 0; n < 3; n++) begin
      step();
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL lim10_pulse_once got=%0b want=0", timeout); end
      total++; if (expired !== 1'b1 || count !== 32'd10) begin bad++; $display("FAIL lim10_sticky expired=%0b count=%0d want 1/10", expired, count); end
    end
  endtask

  task automatic test_disabled();
    apply_reset(32'd0);
    for (int i = 0; i < 100; i++) begin
      kick  = (i % 3) == 0;
      pause = (i % 5) == 0;
      step();
      total++; if (state !== 2'd0 || count !== 32'd0) begin bad++; $display("FAIL dis_idle cyc=%0d state=%0d count=%0d want 0/0", i, state, count); end
    end
    kick = 1'b0;
    pause = 1'b0;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_limit = 32'd5;
    #1;
    total++; if (wr_bus.wr_ready !== 1'b1) begin bad++; $display("FAIL dis_wr_ready got=%0b want=1", wr_bus.wr_ready); end
    step();
    wr_bus.wr_valid = 1'b0;
    total++; if (state !== 2'd1 || count !== 32'd0) begin bad++; $display("FAIL dis_wr_run state=%0d count=%0d want 1/0", state, count); end
    for (int n = 1; n <= 5; n++) begin
      step();
      total++; if (timeout !== (n == 5)) begin bad++; $display("FAIL dis_timeout cyc=%0d got=%0b want=%0b", n, timeout, (n == 5)); end
    end
  endtask

  task automatic test_pause_kick();
    apply_reset(32'd20);
    for (int n = 0; n < 7; n++) step();
    total++; if (count !== 32'd7) begin bad++; $display("FAIL pk_count7 got=%0d want=7", count); end
    pause = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      total++; if (count !== 32'd7 || state !== 2'd2) begin bad++; $display("FAIL pk_hold cyc=%0d count=%0d state=%0d want 7/2", n, count, state); end
    end
    pause = 1'b0;
    step();
    total++; if (state !== 2'd1 || count !== 32'd7) begin bad++; $display("FAIL pk_resume state=%0d count=%0d want 1/7", state, count); end
    for (int n = 0; n < 8; n++) step();
    total++; if (count !== 32'd15) begin bad++; $display("FAIL pk_count15 got=%0d want=15", count); end
    kick = 1'b1;
    step();
    kick = 1'b0;
    total++; if (count !== 32'd0 || state !== 2'd1) begin bad++; $display("FAIL pk_kick count=%0d state=%0d want 0/1", count, state); end
    for (int n = 1; n <= 20; n++) begin
      step();
      total++; if (timeout !== (n == 20)) begin bad++; $display("FAIL pk_timeout cyc=%0d got=%0b want=%0b", n, timeout, (n == 20)); end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset(32'd4);
    for (int n = 0; n < 3; n++) step();
    kick = 1'b1;
    step();
    kick = 1'b0;
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL sim_kick_timeout got=%0b want=0", timeout); end
    total++; if (count !== 32'd0 || state !== 2'd1 || expired !== 1'b0) begin bad++; $display("FAIL sim_kick count=%0d state=%0d expired=%0b want 0/1/0", count, state, expired); end
    for (int n = 0; n < 3; n++) step();
    pause = 1'b1;
    step();
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL sim_pause_timeout got=%0b want=1", timeout); end
    total++; if (state !== 2'd3 || count !== 32'd4 || expired !== 1'b1) begin bad++; $display("FAIL sim_pause state=%0d count=%0d expired=%0b want 3/4/1", state, count, expired); end
    step();
    pause = 1'b0;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL sim_exp_pause_ignored got=%0d want=3", state); end
    kick = 1'b1;
    step();
    kick = 1'b0;
    total++; if (state !== 2'd1 || count !== 32'd0 || expired !== 1'b0) begin bad++; $display("FAIL sim_exp_kick state=%0d count=%0d expired=%0b want 1/0/0", state, count, expired); end
  endtask

  task automatic test_write_expired();
    apply_reset(32'd2);
    step();
    step();
    total++; if (timeout !== 1'b1 || state !== 2'd3) begin bad++; $display("FAIL we_expire timeout=%0b state=%0d want 1/3", timeout, state); end
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_limit = 32'd1;
    step();
    wr_bus.wr_valid = 1'b0;
    total++; if (state !== 2'd1 || count !== 32'd0 || expired !== 1'b0) begin bad++; $display("FAIL we_restart state=%0d count=%0d expired=%0b want 1/0/0", state, count, expired); end
    step();
    total++; if (timeout !== 1'b1 || count !== 32'd1 || state !== 2'd3) begin bad++; $display("FAIL we_limit1 timeout=%0b count=%0d state=%0d want 1/1/3", timeout, count, state); end
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_limit = 32'hFFFF_FFFF;
    step();
    wr_bus.wr_valid = 1'b0;
    for (int n = 0; n < 3; n++) step();
    total++; if (count !== 32'd3 || timeout !== 1'b0 || state !== 2'd1) begin bad++; $display("FAIL we_allones count=%0d timeout=%0b state=%0d want 3/0/1", count, timeout, state); end
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_limit = 32'd0;
    step();
    wr_bus.wr_valid = 1'b0;
    total++; if (state !== 2'd0 || count !== 32'd0) begin bad++; $display("FAIL we_disable state=%0d count=%0d want 0/0", state, count); end
  endtask

  task automatic test_reset_mid();
    apply_reset(32'd50);
    for (int n = 0; n < 30; n++) step();
    total++; if (count !== 32'd30) begin bad++; $display("FAIL rm_count30 got=%0d want=30", count); end
    reset = 1'b1;
    cfg_limit = 32'd8;
    step();
    total++; if (count !== 32'd0 || timeout !== 1'b0 || expired !== 1'b0 || wr_bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rm_clear count=%0d timeout=%0b expired=%0b ready=%0b want 0/0/0/0", count, timeout, expired, wr_bus.wr_ready); end
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      total++; if (timeout !== (n == 8)) begin bad++; $display("FAIL rm_timeout cyc=%0d got=%0b want=%0b", n, timeout, (n == 8)); end
    end
  endtask

`ifdef PLUSARG_TIMEOUT_PRESCALE_EN
  task automatic test_prescale();
    apply_reset(32'd3);
    for (int n = 1; n <= 12; n++) begin
      step();
      total++; if (timeout !== (n == 12)) begin bad++; $display("FAIL ps_timeout cyc=%0d got=%0b want=%0b", n, timeout, (n == 12)); end
      total++; if (count !== 32'(n / 4)) begin bad++; $display("FAIL ps_count cyc=%0d got=%0d want=%0d", n, count, n / 4); end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    cfg_limit = 32'd0;
    kick = 1'b0;
    pause = 1'b0;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_limit = 32'd0;
    test_reset();
`ifdef PLUSARG_TIMEOUT_PRESCALE_EN
    test_prescale();
`else
    test_limit10();
    test_disabled();
    test_pause_kick();
    test_simultaneous();
    test_write_expired();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plusarg_timeout_ctrl.md
Name: plusarg_timeout_ctrl

Overview:
- Cycle-limit watchdog sequencer driven by the 32-bit plusarg configuration value (e.g. a max-cycles setting). Used in the test harness and in the SoC debug path.
- Latches the limit at reset and counts run cycles. Accepts kicks, pause and runtime limit overrides through a valid/ready write port.
- Signals expiry with a one-cycle pulse plus a sticky flag.
- A latched limit of 0 means disabled.

Parameters:
- WIDTH, 32, counter and limit width; must be at least 8 and at most 32.
- PRESCALE_LOG2, 4, the counter advances every 2^PRESCALE_LOG2 cycles. Used only when the optional feature is compiled in.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cfg_limit  in  32  plusarg-supplied limit, sampled only while reset is high. Lower WIDTH bits are used; upper bits are ignored.
- wr_valid  in  1  runtime limit override request.
- wr_ready  out  1  override accepted this cycle when wr_valid and wr_ready are both high.
- wr_limit  in  WIDTH  new limit value.
- kick  in  1  restart the count from 0.
- pause  in  1  hold the count while high.
- count  out  WIDTH  current count.
- state  out  2  encoding: 0 IDLE, 1 RUN, 2 PAUSED, 3 EXPIRED.
- timeout  out  1  single-cycle pulse on expiry.
- expired  out  1  sticky expiry flag, cleared by kick or by an accepted write.

Behaviour:
- Reset (synchronous): limit_q <= cfg_limit[WIDTH-1:0] every cycle reset is high. At reset, count=0, timeout=0, expired=0, wr_ready=0.
- First cycle after reset: state = RUN if limit_q != 0, otherwise IDLE.
- wr_ready = !reset, so an override is accepted in any state. An accepted write sets limit_q <= wr_limit, count <= 0, expired <= 0. Next state is RUN if wr_limit != 0, otherwise IDLE.
- IDLE: count holds at 0. kick and pause have no effect. Only an accepted write leaves IDLE.
- RUN:
  - count increments by 1 per cycle (per tick with the prescaler).
  - When the incremented value equals limit_q: count <= limit_q, timeout pulses high for exactly 1 cycle, expired <= 1, state <= EXPIRED.
  - With limit L, timeout is high in the cycle in which count == L is first registered: L cycles after entering RUN, and L cycles after a kick.
- pause high while in RUN: state <= PAUSED next cycle and count holds. pause low while in PAUSED: state <= RUN and counting resumes.
- An expiry increment and a pause arriving in the same cycle: expiry wins.
- EXPIRED: count holds at limit_q. A kick or an accepted write returns to RUN with count <= 0 and expired <= 0. pause is ignored.
- kick in RUN or PAUSED: count <= 0 and the state is unchanged.
- Priority within a cycle, highest first: reset, accepted write, kick, expiry, pause. A kick in the expiry cycle suppresses the timeout pulse.
- Limit of 1: timeout fires 1 cycle after RUN is entered.
- Arithmetic: count is an unsigned WIDTH-bit value. The count never exceeds limit_q, so no wrap is reachable. A limit of all-ones is legal.
- Reset asserted mid-count: everything clears and cfg_limit is re-sampled.

Optional Feature:
- Macro: PLUSARG_TIMEOUT_PRESCALE_EN.
- Defined: a free-running PRESCALE_LOG2-bit prescaler, cleared on reset, kick or accepted write, generates a tick every 2^PRESCALE_LOG2 cycles. count advances only on ticks in RUN; the prescaler holds while in PAUSED. Expiry latency becomes L × 2^PRESCALE_LOG2 cycles.
- Undefined: a tick occurs every cycle, there is no prescaler logic, and PRESCALE_LOG2 is unused.

Decomposition:
- Shared package plusarg_timeout_pkg holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, EXPIRED=2'd3;
  - the LIMIT_DISABLED=0 constant;
  - the state typedef.
- One natural sub-module: plusarg_timeout_tick, which contains the prescaler and tick generation. It is a pass-through tick=1 when the macro is undefined.

Test Plan:
- Limit 10: reset with cfg_limit=10 and deassert reset → count reaches 10, timeout pulses exactly once 10 cycles after reset release, state=3, expired=1 and stays high.
- Disabled: cfg_limit=0 → state=0 and count=0 for 100 cycles. Then write wr_limit=5 → wr_ready=1, state=1, timeout 5 cycles later.
- Pause and kick: limit 20, pause at count 7 for 5 cycles → count holds at 7 and state=2, then resumes; a kick at count 15 → count=0 and timeout arrives 20 cycles after the kick.
- Simultaneous events: kick in the expiry cycle → no timeout pulse and count=0. pause in the expiry cycle → timeout pulses and state=3.
- Reset mid-run: limit 50, reset at count 30 with cfg_limit=8 → all outputs cleared, and the timeout arrives 8 cycles after reset release.
- Prescale (macro defined, PRESCALE_LOG2=2): limit 3 → timeout 12 cycles after RUN is entered.
